smp_gain_alu_client: RTL

- Stereo sample gain stage, MIDI-controlled volume (CC7) on one channel.
- On each sample trigger it issues one multiply transaction as an initiator on the shared ALU client bus (cycle/strobe/ack/stall) and registers the scaled left/right result.
- It sits between a sound generator's stereo output and the mixer, and shares an ALU port like any other generator client.
- The gain slews toward the MIDI target, one step per sample, to avoid zipper noise.

---
 rtl/smp_gain_alu_client.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/smp_gain_alu_client.sv
// smp_gain_alu_client
//   Stereo gain stage with a MIDI CC7 volume control. Every accepted sample
//   trigger issues one multiply (P = A*B + C) on the shared ALU client bus.
//   The left/right samples are the A operands and the current gain is the B
//   operand. The product is rescaled and registered as the output sample.
//   Each trigger slews the gain toward the MIDI target by at most GAIN_STEP.
//   This avoids zipper noise on volume changes.
//
// Ports
//   clk, reset (async, active-low)
//   midi_rdy/midi_cmd/midi_ch_sysn/midi_data0/midi_data1 : decoded MIDI input
//   smp_trig, smp_in_l, smp_in_r      : input sample strobe and data
//   smp_out_rdy, smp_out_l, smp_out_r : scaled sample strobe and data (held)
//   overrun                           : sticky, trigger arrived while busy
//   alu_cycle/alu_strobe/alu_stall/alu_ack, alu_op, alu_a*/b*/c*, alu_p* :
//                                       ALU client bus, initiator side

`ifndef MIDI_CMD_SIZE
`define MIDI_CMD_SIZE 3
`endif
`ifndef MIDI_CMD_CC
`define MIDI_CMD_CC 3'd3
`endif

module smp_gain_alu_client #(
  parameter logic [3:0]  MIDI_CH    = 4'd0,
  parameter logic [6:0]  DEF_VOL    = 7'd100,
  parameter logic [17:0] GAIN_STEP  = 18'd1024,
  parameter logic [8:0]  ALU_OP_MUL = 9'h001
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      midi_rdy,
  input  logic [`MIDI_CMD_SIZE-1:0] midi_cmd,
  input  logic [3:0]                midi_ch_sysn,
  input  logic [6:0]                midi_data0,
  input  logic [6:0]                midi_data1,
  input  logic                      smp_trig,
  input  logic signed [17:0]        smp_in_l,
  input  logic signed [17:0]        smp_in_r,
  output logic                      smp_out_rdy,
  output logic signed [17:0]        smp_out_l,
  output logic signed [17:0]        smp_out_r,
  output logic                      overrun,
  output logic                      alu_cycle,
  output logic                      alu_strobe,
  input  logic                      alu_ack,
  input  logic                      alu_stall,
  output logic [8:0]                alu_op,
  output logic signed [17:0]        alu_al,
  output logic signed [17:0]        alu_ar,
  output logic signed [17:0]        alu_bl,
  output logic signed [17:0]        alu_br,
  output logic signed [47:0]        alu_cl,
  output logic signed [47:0]        alu_cr,
  input  logic signed [47:0]        alu_pl,
  input  logic signed [47:0]        alu_pr
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK, OUT} state_t;

  localparam logic [17:0] DEF_GAIN = {1'b0, DEF_VOL, 10'b0};

  state_t      state, state_next;
  logic [17:0] gain_cur, gain_tgt, gain_next;
  logic        midi_hit, capture;
  logic        unused_p_bits;

  assign alu_op = ALU_OP_MUL;
  assign alu_cl = '0;
  assign alu_cr = '0;

  // Only bits [34:17] of the Q1.17 product form the output sample.
  assign unused_p_bits = ^{alu_pl[47:35], alu_pl[16:0], alu_pr[47:35], alu_pr[16:0]};

  assign midi_hit = midi_rdy && (midi_cmd == `MIDI_CMD_CC) &&
                    (midi_ch_sysn == MIDI_CH) && (midi_data0 == 7'd7);

  // An ack in REQ is only meaningful once the request is accepted.
  assign capture = ((state == REQ) && !alu_stall && alu_ack) ||
                   ((state == WAIT_ACK) && alu_ack);

  // Step toward the target by at most GAIN_STEP, landing exactly on it.
  always_comb begin
    gain_next = gain_cur;
    if (gain_tgt > gain_cur) begin
      if ((gain_tgt - gain_cur) > GAIN_STEP) gain_next = gain_cur + GAIN_STEP;
      else                                   gain_next = gain_tgt;
    end else if (gain_tgt < gain_cur) begin
      if ((gain_cur - gain_tgt) > GAIN_STEP) gain_next = gain_cur - GAIN_STEP;
      else                                   gain_next = gain_tgt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    alu_cycle   = 1'b0;
    alu_strobe  = 1'b0;
    smp_out_rdy = 1'b0;
    case (state)
      IDLE: begin
        if (smp_trig) state_next = REQ;
      end
      REQ: begin
        alu_cycle  = 1'b1;
        alu_strobe = 1'b1;
        if (!alu_stall) state_next = alu_ack ? OUT : WAIT_ACK;
      end
      WAIT_ACK: begin
        alu_cycle = 1'b1;
        if (alu_ack) state_next = OUT;
      end
      OUT: begin
        smp_out_rdy = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The operands are latched once per trigger and are held through any stall.
  // The bus requires them stable until the request is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gain_cur  <= DEF_GAIN;
      gain_tgt  <= DEF_GAIN;
      alu_al    <= '0;
      alu_ar    <= '0;
      alu_bl    <= '0;
      alu_br    <= '0;
      smp_out_l <= '0;
      smp_out_r <= '0;
      overrun   <= 1'b0;
    end else begin
      if (midi_hit) gain_tgt <= {1'b0, midi_data1, 10'b0};
      if (smp_trig) begin
        if (state == IDLE) begin
          alu_al   <= smp_in_l;
          alu_ar   <= smp_in_r;
          alu_bl   <= gain_next;
          alu_br   <= gain_next;
          gain_cur <= gain_next;
        end else begin
          overrun <= 1'b1;
        end
      end
      if (capture) begin
        smp_out_l <= alu_pl[34:17];
        smp_out_r <= alu_pr[34:17];
      end
    end
  end

endmodule
